conv2d_stream_engine: RTL and testbench

//  Multi-channel 2-D convolution engine, next generation of the single-channel sliding-window conv.

---
 rtl/conv2d_stream_engine.sv | 191 +++++++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_stream_engine.sv
// Multi-channel strided/padded 2-D convolution engine, one MAC per cycle, with
// bias preload, shift/ReLU/saturate post-processing and a valid/ready pixel stream.
module conv2d_stream_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int HEIGHT     = 8,
    parameter int WIDTH      = 8,
    parameter int K          = 3,
    parameter int CIN        = 2,
    parameter int STRIDE     = 1,
    parameter int PAD        = 0,
    localparam int OUT_H     = (HEIGHT + 2*PAD - K) / STRIDE + 1,
    localparam int OUT_W     = (WIDTH + 2*PAD - K) / STRIDE + 1,
    localparam int XW        = $clog2(OUT_W) + 1,
    localparam int YW        = $clog2(OUT_H) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  relu_en,
    input  logic [4:0]                            out_shift,
    input  logic [CIN*HEIGHT*WIDTH*DATA_WIDTH-1:0] matrix,
    input  logic [CIN*K*K*K_WIDTH-1:0]            kernel,
    input  logic [ACC_WIDTH-1:0]                  bias,
    output logic [OUT_WIDTH-1:0]                  out_pixel,
    output logic [XW-1:0]                         out_x,
    output logic [YW-1:0]                         out_y,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int CW = $clog2(CIN) + 1;
    localparam int KW = $clog2(K) + 1;
    localparam int PW = DATA_WIDTH + K_WIDTH;

    localparam logic [CW-1:0] C_LAST = CW'(CIN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] c_cnt;
    logic [KW-1:0] i_cnt, j_cnt;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          relu_q;
    logic [4:0]    shift_q;

    logic signed [ACC_WIDTH-1:0]  acc_p0, acc_sum, shifted;
    logic signed [OUT_WIDTH-1:0]  result;
    logic signed [DATA_WIDTH-1:0] pix;
    logic signed [K_WIDTH-1:0]    coef;
    logic signed [PW-1:0]         prod;
    int   row, col, pix_idx, coef_idx;
    logic in_bounds, last_tap, last_pixel;

    function automatic logic signed [ACC_WIDTH-1:0] shift_floor(
        input logic signed [ACC_WIDTH-1:0] v, input logic [4:0] sh);
        return v >>> sh;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(
        input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return v[OUT_WIDTH-1:0];
    endfunction

    assign last_tap   = (c_cnt == C_LAST) && (i_cnt == K_LAST) && (j_cnt == K_LAST);
    assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    // MAC stage: padded taps read as zero but still take their cycle
    always_comb begin
        row       = int'(y_cnt) * STRIDE + int'(i_cnt) - PAD;
        col       = int'(x_cnt) * STRIDE + int'(j_cnt) - PAD;
        in_bounds = (row >= 0) && (row < HEIGHT) && (col >= 0) && (col < WIDTH);
        pix_idx   = in_bounds ? ((int'(c_cnt) * HEIGHT + row) * WIDTH + col) : 0;
        coef_idx  = (int'(c_cnt) * K + int'(i_cnt)) * K + int'(j_cnt);
        pix       = in_bounds ? matrix[pix_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        coef      = kernel[coef_idx*K_WIDTH +: K_WIDTH];
        prod      = pix * coef;
        acc_sum   = acc_p0 + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end

    // Post-processing of the final sum: floor shift, optional ReLU, saturate
    always_comb begin
        shifted = shift_floor(acc_sum, shift_q);
        if (relu_q && (shifted < 0)) shifted = '0;
        result = saturate(shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_MAC;
            S_MAC:  if (last_tap) state_nxt = S_EMIT;
            S_EMIT: if (out_ready) state_nxt = last_pixel ? S_DONE : S_MAC;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_MAC:  busy = 1'b1;
            S_EMIT: begin busy = 1'b1; out_valid = 1'b1; end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_cnt     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            relu_q    <= 1'b0;
            shift_q   <= '0;
            out_pixel <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    relu_q  <= relu_en;
                    shift_q <= out_shift;
                    c_cnt   <= '0;
                    i_cnt   <= '0;
                    j_cnt   <= '0;
                    x_cnt   <= '0;
                    y_cnt   <= '0;
                end
                S_MAC: begin
                    if (j_cnt == K_LAST) begin
                        j_cnt <= '0;
                        if (i_cnt == K_LAST) begin
                            i_cnt <= '0;
                            c_cnt <= (c_cnt == C_LAST) ? '0 : c_cnt + 1'b1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                    if (last_tap) out_pixel <= result;
                end
                S_EMIT: if (out_ready && !last_pixel) begin
                    if (x_cnt == X_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + 1'b1;
                    end else begin
                        x_cnt <= x_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator is pure data: preloaded with bias at every pixel start
    always_ff @(posedge clk) begin
        if (((state == S_IDLE) && start) || ((state == S_EMIT) && out_ready))
            acc_p0 <= $signed(bias);
        else if (state == S_MAC)
            acc_p0 <= acc_sum;
    end

    assign out_x = x_cnt;
    assign out_y = y_cnt;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: four configurations share clock/reset,
// one is observed at a time through a mux selected by sel.
module tb_conv2d_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, relu_en, ready;
    logic [4:0]  out_shift;
    logic [31:0] bias;
    logic [3:0]  start_v;
    int          sel;

    logic [127:0] mat_a, mat_b;
    logic [31:0]  ker_a;
    logic [71:0]  ker_b;
    logic [63:0]  mat_c, ker_c;

    logic [15:0] px0, px1, px2, px3;
    logic [2:0]  x0, y0, x2, y2;
    logic [1:0]  x1, y1;
    logic [0:0]  x3, y3;
    logic        v0, v1, v2, v3, b0, b1, b2, b3, d0, d1, d2, d3;
    logic        r0, r1, r2, r3;

    assign r0 = (sel == 0) ? ready : 1'b1;
    assign r1 = (sel == 1) ? ready : 1'b1;
    assign r2 = (sel == 2) ? ready : 1'b1;
    assign r3 = (sel == 3) ? ready : 1'b1;

    conv2d_stream_engine #(.HEIGHT(4), .WIDTH(4), .K(2), .CIN(1), .STRIDE(1), .PAD(0)) u_t1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .relu_en(relu_en), .out_shift(out_shift),
        .matrix(mat_a), .kernel(ker_a), .bias(bias), .out_pixel(px0), .out_x(x0), .out_y(y0),
        .out_valid(v0), .out_ready(r0), .busy(b0), .done(d0));

    conv2d_stream_engine #(.HEIGHT(4), .WIDTH(4), .K(2), .CIN(1), .STRIDE(2), .PAD(0)) u_t2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .relu_en(relu_en), .out_shift(out_shift),
        .matrix(mat_a), .kernel(ker_a), .bias(bias), .out_pixel(px1), .out_x(x1), .out_y(y1),
        .out_valid(v1), .out_ready(r1), .busy(b1), .done(d1));

    conv2d_stream_engine #(.HEIGHT(4), .WIDTH(4), .K(3), .CIN(1), .STRIDE(1), .PAD(1)) u_t3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .relu_en(relu_en), .out_shift(out_shift),
        .matrix(mat_b), .kernel(ker_b), .bias(bias), .out_pixel(px2), .out_x(x2), .out_y(y2),
        .out_valid(v2), .out_ready(r2), .busy(b2), .done(d2));

    conv2d_stream_engine #(.HEIGHT(2), .WIDTH(2), .K(2), .CIN(2), .STRIDE(1), .PAD(0)) u_t5 (
        .clk(clk), .rst(rst), .start(start_v[3]), .relu_en(relu_en), .out_shift(out_shift),
        .matrix(mat_c), .kernel(ker_c), .bias(bias), .out_pixel(px3), .out_x(x3), .out_y(y3),
        .out_valid(v3), .out_ready(r3), .busy(b3), .done(d3));

    logic [15:0] obs_pixel;
    logic [7:0]  obs_x, obs_y;
    logic        obs_valid, obs_busy, obs_done;

    always_comb begin
        obs_pixel = px0; obs_x = 8'(x0); obs_y = 8'(y0);
        obs_valid = v0;  obs_busy = b0;  obs_done = d0;
        case (sel)
            1: begin obs_pixel = px1; obs_x = 8'(x1); obs_y = 8'(y1);
                     obs_valid = v1; obs_busy = b1; obs_done = d1; end
            2: begin obs_pixel = px2; obs_x = 8'(x2); obs_y = 8'(y2);
                     obs_valid = v2; obs_busy = b2; obs_done = d2; end
            3: begin obs_pixel = px3; obs_x = 8'(x3); obs_y = 8'(y3);
                     obs_valid = v3; obs_busy = b3; obs_done = d3; end
            default: ;
        endcase
    end

    int checks = 0;
    int failures = 0;
    logic signed [31:0] exp_pix [16];
    logic signed [31:0] exp_x [16];
    logic signed [31:0] exp_y [16];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Starts the selected engine and checks every pixel, its spacing, and the done pulse.
    task automatic run_frame(input int n, input int gap, input int stall_idx, input int stall_len);
        int cnt;
        @(negedge clk);
        start_v[sel[1:0]] = 1'b1;
        @(negedge clk);
        start_v = '0;
        chk("busy_after_start", 32'(obs_busy), 1);
        chk("valid_after_start", 32'(obs_valid), 0);
        for (int k = 0; k < n; k++) begin
            if (k == stall_idx) ready = 1'b0;
            cnt = 0;
            while (!obs_valid && cnt < 400) begin
                @(negedge clk);
                cnt++;
            end
            chk("pixel_latency", cnt, gap - 1);
            chk("pixel_value", $signed(obs_pixel), exp_pix[k]);
            chk("pixel_x", 32'(obs_x), exp_x[k]);
            chk("pixel_y", 32'(obs_y), exp_y[k]);
            if (k == stall_idx) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(obs_valid), 1);
                    chk("stall_pixel", $signed(obs_pixel), exp_pix[k]);
                    chk("stall_x", 32'(obs_x), exp_x[k]);
                    chk("stall_y", 32'(obs_y), exp_y[k]);
                end
                ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_pulse", 32'(obs_done), 1);
        chk("busy_at_done", 32'(obs_busy), 0);
        chk("valid_at_done", 32'(obs_valid), 0);
        @(negedge clk);
        chk("done_cleared", 32'(obs_done), 0);
    endtask

    task automatic load_t1;
        int t1v [9] = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
        for (int k = 0; k < 9; k++) begin
            exp_pix[k] = t1v[k];
            exp_x[k]   = k % 3;
            exp_y[k]   = k / 3;
        end
    endtask

    initial begin
        int cnt;
        int t2v [4] = '{14, 22, 46, 54};
        rst = 1'b1; start_v = '0; ready = 1'b1; relu_en = 1'b0; out_shift = '0; bias = '0; sel = 0;
        for (int k = 0; k < 16; k++) mat_a[k*8 +: 8] = 8'(k + 1);
        ker_a = {4{8'd1}};
        mat_b = {16{8'd1}};
        ker_b = {9{8'd1}};
        mat_c = {8{8'd127}};
        ker_c = {8{8'd127}};
        repeat (2) @(negedge clk);

        chk("reset_valid", 32'(obs_valid), 0);
        chk("reset_busy", 32'(obs_busy), 0);
        chk("reset_done", 32'(obs_done), 0);
        chk("reset_pixel", 32'(obs_pixel), 0);
        chk("reset_x", 32'(obs_x), 0);
        chk("reset_y", 32'(obs_y), 0);
        rst = 1'b0;

        // T1: 4x4 ramp, 2x2 ones kernel
        sel = 0;
        load_t1();
        run_frame(9, 5, -1, 0);

        // T2: stride 2
        sel = 1;
        for (int k = 0; k < 4; k++) begin
            exp_pix[k] = t2v[k]; exp_x[k] = k % 2; exp_y[k] = k / 2;
        end
        run_frame(4, 5, -1, 0);

        // T3: 3x3 ones with one-pixel zero border
        sel = 2;
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 4; xx++) begin
                exp_pix[yy*4 + xx] = ((xx == 0 || xx == 3) ? 2 : 3) * ((yy == 0 || yy == 3) ? 2 : 3);
                exp_x[yy*4 + xx]   = xx;
                exp_y[yy*4 + xx]   = yy;
            end
        run_frame(16, 10, -1, 0);

        // T4: back-pressure on the second pixel
        sel = 0;
        load_t1();
        run_frame(9, 5, 1, 5);

        // T6: reset mid-MAC, then mid-EMIT, then a clean frame
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(obs_busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_mac_valid", 32'(obs_valid), 0);
        chk("rst_mac_busy", 32'(obs_busy), 0);
        chk("rst_mac_done", 32'(obs_done), 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        cnt = 0;
        while (!obs_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("emit_reached", 32'(obs_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_emit_valid", 32'(obs_valid), 0);
        chk("rst_emit_busy", 32'(obs_busy), 0);
        chk("rst_emit_done", 32'(obs_done), 0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'(obs_valid), 0);
        run_frame(9, 5, -1, 0);

        // T5: two channels, saturation, ReLU, bias with shift
        sel = 3;
        exp_x[0] = 0; exp_y[0] = 0;
        exp_pix[0] = 32767;
        run_frame(1, 9, -1, 0);
        ker_c = {8{8'h80}};
        exp_pix[0] = -32768;
        run_frame(1, 9, -1, 0);
        relu_en = 1'b1;
        exp_pix[0] = 0;
        run_frame(1, 9, -1, 0);
        relu_en = 1'b0;
        ker_c = '0;
        bias = -32'sd1000;
        out_shift = 5'd2;
        exp_pix[0] = -250;
        run_frame(1, 9, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
